// File: rtl/approx_eval_pkg.sv
// Shared types and helpers for exact/approximate circuit evaluators.
// State encoding plus an unsigned error-magnitude function.
package approx_eval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned ERR_W = 16;

  function automatic logic [ERR_W-1:0] abs_err(
    input logic [ERR_W-1:0] a,
    input logic [ERR_W-1:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/abs_err_acc.sv
// Second stage: per-vector error magnitude and the four sweep statistics.
// Clear wins over valid so a restart always begins from zero.
module abs_err_acc
  import approx_eval_pkg::*;
#(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 3,
  parameter int unsigned ET    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  valid,
  input  logic [OUT_W-1:0]      exact,
  input  logic [OUT_W-1:0]      approx,
  output logic [OUT_W-1:0]      max_err,
  output logic [IN_W:0]         err_cnt,
  output logic [OUT_W+IN_W-1:0] err_sum,
  output logic                  violation
);

  logic [OUT_W-1:0]      w_d;
  logic                  w_nz;
  logic                  w_over;
  logic [OUT_W-1:0]      r_max;
  logic [IN_W:0]         r_cnt;
  logic [OUT_W+IN_W-1:0] r_sum;
  logic                  r_viol;

  assign w_d    = OUT_W'(abs_err(ERR_W'(exact), ERR_W'(approx)));
  assign w_nz   = (w_d != '0);
  assign w_over = (32'(w_d) > ET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max  <= '0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_viol <= 1'b0;
    end else if (clr) begin
      r_max  <= '0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_viol <= 1'b0;
    end else if (valid) begin
      if (w_d > r_max) r_max <= w_d;
      r_cnt  <= r_cnt + (IN_W+1)'(w_nz);
      r_sum  <= r_sum + (OUT_W+IN_W)'(w_d);
      r_viol <= r_viol | w_over;
    end
  end

  assign max_err   = r_max;
  assign err_cnt   = r_cnt;
  assign err_sum   = r_sum;
  assign violation = r_viol;

endmodule

// File: rtl/approx_error_monitor.sv
// Sweeps every input vector through an exact/approx circuit pair
// and reports max, count and sum of absolute error plus a sticky flag.
module approx_error_monitor
  import approx_eval_pkg::*;
#(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 3,
  parameter int unsigned ET    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [IN_W-1:0]       vec_o,
  input  logic [OUT_W-1:0]      exact_i,
  input  logic [OUT_W-1:0]      approx_i,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_W-1:0]      max_err,
  output logic [IN_W:0]         err_cnt,
  output logic [OUT_W+IN_W-1:0] err_sum,
  output logic                  violation
);

  localparam logic [IN_W-1:0] VEC_LAST = '1;

  state_t           r_state;
  state_t           w_next;
  logic             w_clr;
  logic [IN_W-1:0]  r_vec;
  logic             r_s1_valid;
  logic [OUT_W-1:0] r_s1_exact;
  logic [OUT_W-1:0] r_s1_approx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next = SWEEP;
          w_clr  = 1'b1;
        end
      end
      SWEEP: begin
        if (r_vec == VEC_LAST) w_next = DRAIN;
      end
      DRAIN: w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // Counter parks on the last vector so DONE keeps showing it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec <= '0;
    end else if (w_clr) begin
      r_vec <= '0;
    end else if (r_state == SWEEP && r_vec != VEC_LAST) begin
      r_vec <= r_vec + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_exact  <= '0;
      r_s1_approx <= '0;
    end else begin
      r_s1_valid <= (r_state == SWEEP);
      if (r_state == SWEEP) begin
        r_s1_exact  <= exact_i;
        r_s1_approx <= approx_i;
      end
    end
  end

  abs_err_acc #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .ET    (ET)
  ) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (w_clr),
    .valid     (r_s1_valid),
    .exact     (r_s1_exact),
    .approx    (r_s1_approx),
    .max_err   (max_err),
    .err_cnt   (err_cnt),
    .err_sum   (err_sum),
    .violation (violation)
  );

  assign vec_o = r_vec;
  assign busy  = (r_state == SWEEP) || (r_state == DRAIN);
  assign done  = (r_state == DONE);

endmodule

// File: tb/tb_approx_error_monitor.sv
// Bench for approx_error_monitor: ET=4 and ET=2 instances,
// a sweep-level reference model and directed literal checks.
module tb_approx_error_monitor;

  logic       clk;
  logic       rst_n;
  logic       start;
  int         mode;

  logic [3:0] vec1, vec2;
  logic [2:0] ex1, ap1, ex2, ap2;
  logic       busy1, done1, viol1;
  logic       busy2, done2, viol2;
  logic [2:0] max1, max2;
  logic [4:0] cnt1, cnt2;
  logic [6:0] sum1, sum2;

  int checks;
  int failures;

  approx_error_monitor #(.IN_W(4), .OUT_W(3), .ET(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_o(vec1),
    .exact_i(ex1), .approx_i(ap1), .busy(busy1), .done(done1),
    .max_err(max1), .err_cnt(cnt1), .err_sum(sum1),
    .violation(viol1)
  );

  approx_error_monitor #(.IN_W(4), .OUT_W(3), .ET(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_o(vec2),
    .exact_i(ex2), .approx_i(ap2), .busy(busy2), .done(done2),
    .max_err(max2), .err_cnt(cnt2), .err_sum(sum2),
    .violation(viol2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Circuit pair models: exact = |in[1:0]-in[3:2]|
  function automatic int exact_f(input int m, input int v);
    int a, b;
    a = v & 3;
    b = (v >> 2) & 3;
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int approx_f(input int m, input int v);
    int e;
    e = exact_f(m, v);
    case (m)
      1:       return 0;
      2:       return (v == 5) ? (e ^ 4) : e;
      3:       return v & 7;
      default: return e;
    endcase
  endfunction

  always_comb begin
    ex1 = 3'(exact_f(mode, int'(vec1)));
    ap1 = 3'(approx_f(mode, int'(vec1)));
    ex2 = 3'(exact_f(mode, int'(vec2)));
    ap2 = 3'(approx_f(mode, int'(vec2)));
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Model: cycles since the accepted start, plus the run's mode.
  bit m_active;
  int m_k;
  int m_mode;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_mode   <= 0;
    end else if (start && (!m_active || m_k >= 17)) begin
      m_active <= 1'b1;
      m_k      <= 0;
      m_mode   <= mode;
    end else if (m_active && m_k < 17) begin
      m_k <= m_k + 1;
    end
  end

  // Stats over the first n vectors of a sweep.
  task automatic stats(input int m, input int n, output int mx,
                       output int cn, output int sm,
                       output int v4, output int v2);
    int d;
    mx = 0; cn = 0; sm = 0; v4 = 0; v2 = 0;
    for (int j = 0; j < n; j++) begin
      d = exact_f(m, j) - approx_f(m, j);
      if (d < 0) d = -d;
      if (d > mx) mx = d;
      if (d != 0) cn++;
      sm += d;
      if (d > 4) v4 = 1;
      if (d > 2) v2 = 1;
    end
  endtask

  always @(negedge clk) begin
    int n, ev, eb, ed, mx, cn, sm, v4, v2;
    n = 0; ev = 0; eb = 0; ed = 0;
    if (m_active) begin
      ev = (m_k < 15) ? m_k : 15;
      eb = (m_k < 17) ? 1 : 0;
      ed = (m_k == 17) ? 1 : 0;
      n  = (m_k >= 2) ? ((m_k - 1 > 16) ? 16 : m_k - 1) : 0;
    end
    stats(m_mode, n, mx, cn, sm, v4, v2);
    chk("vec_o",     32'(vec1),  32'(ev));
    chk("busy",      32'(busy1), 32'(eb));
    chk("done",      32'(done1), 32'(ed));
    chk("max_err",   32'(max1),  32'(mx));
    chk("err_cnt",   32'(cnt1),  32'(cn));
    chk("err_sum",   32'(sum1),  32'(sm));
    chk("violation", 32'(viol1), 32'(v4));
    chk("viol_et2",  32'(viol2), 32'(v2));
    chk("busy_done", 32'(busy1 & done1), 32'd0);
  end

  task automatic final_lit(input string nm, input int mx, input int cn,
                           input int sm, input int v4, input int v2);
    chk({nm, "_max"},  32'(max1), 32'(mx));
    chk({nm, "_cnt"},  32'(cnt1), 32'(cn));
    chk({nm, "_sum"},  32'(sum1), 32'(sm));
    chk({nm, "_viol"}, 32'(viol1), 32'(v4));
    chk({nm, "_v2"},   32'(viol2), 32'(v2));
    chk({nm, "_vec"},  32'(vec1), 32'd15);
  endtask

  task automatic wait_done(input string nm);
    int lat;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done1) begin
        lat = i;
        break;
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'd17);
  endtask

  task automatic run_sweep(input int m, input string nm);
    @(posedge clk);
    #1;
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(nm);
  endtask

  task automatic zeros(input string nm);
    chk({nm, "_vec"},  32'(vec1),  32'd0);
    chk({nm, "_busy"}, 32'(busy1), 32'd0);
    chk({nm, "_done"}, 32'(done1), 32'd0);
    chk({nm, "_max"},  32'(max1),  32'd0);
    chk({nm, "_cnt"},  32'(cnt1),  32'd0);
    chk({nm, "_sum"},  32'(sum1),  32'd0);
    chk({nm, "_viol"}, 32'(viol1), 32'd0);
    chk({nm, "_v2"},   32'(viol2), 32'd0);
  endtask

  initial begin
    bit hit;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    mode     = 0;
    #12;
    zeros("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_sweep(0, "t1");
    final_lit("t1", 0, 0, 0, 0, 0);

    run_sweep(1, "t2");
    final_lit("t2", 3, 12, 20, 0, 1);

    run_sweep(2, "t3");
    final_lit("t3", 4, 1, 4, 0, 1);

    // Start held high across the whole sweep.
    @(posedge clk);
    #1;
    mode  = 1;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done("t4");
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t4_hold_done", 32'(done1), 32'd1);
    final_lit("t4", 3, 12, 20, 0, 1);
    @(posedge clk);
    #1;
    mode  = 2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("t4_clr_cnt", 32'(cnt1), 32'd0);
    chk("t4_clr_sum", 32'(sum1), 32'd0);
    chk("t4_busy",    32'(busy1), 32'd1);
    wait_done("t4b");
    final_lit("t4b", 4, 1, 4, 0, 1);

    // Asynchronous reset in mid-sweep.
    @(posedge clk);
    #1;
    mode  = 1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (vec1 == 4'd7) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("t5_reach7", 32'(hit), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    zeros("t5_async");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    run_sweep(1, "t5");
    final_lit("t5", 3, 12, 20, 0, 1);

    run_sweep(3, "t6a");
    final_lit("t6a", 7, 11, 40, 1, 1);
    run_sweep(2, "t6b");
    final_lit("t6b", 4, 1, 4, 0, 1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
